// File: rtl/mux_rr_nd_if.sv
// Channel-side and sink-side handshake bundle for mux_rr_nd.
// The master drives the producers and the sink; the slave is the mux itself.
interface mux_rr_nd_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
);
    localparam int SELW = $clog2(CHANNELS);

    logic                         mode;
    logic [SELW-1:0]              mux_ctl;
    logic [CHANNELS*WIDTH-1:0]    din;
    logic [CHANNELS-1:0]          din_valid;
    logic [CHANNELS-1:0]          din_ready;
    logic [WIDTH-1:0]             mux_out;
    logic [SELW-1:0]              out_sel;
    logic                         out_valid;
    logic                         out_ready;

    modport master (
        output mode, mux_ctl, din, din_valid, out_ready,
        input  din_ready, mux_out, out_sel, out_valid
    );

    modport slave (
        input  mode, mux_ctl, din, din_valid, out_ready,
        output din_ready, mux_out, out_sel, out_valid
    );
endinterface

// File: rtl/mux_rr_nd.sv
// N-channel valid/ready mux with fixed or round-robin selection feeding a
// single-entry registered output stage that sustains one word per cycle.
module mux_rr_nd_lane #(
    parameter int WIDTH = 32
) (
    input  logic             grant,
    input  logic             can_accept,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic             ready,
    output logic [WIDTH-1:0] data
);
    assign ready = grant && can_accept && !reset;
    // Zero non-granted lanes so the top can OR-reduce instead of muxing.
    assign data  = grant ? din : '0;
endmodule

module mux_rr_nd #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4
) (
    input  logic        clk,
    input  logic        reset,
    mux_rr_nd_if.slave  bus
);
    localparam int SELW = $clog2(CHANNELS);

    logic [SELW-1:0]                 last_grant_q, last_grant_d;
    logic [SELW-1:0]                 out_sel_q, out_sel_d;
    logic [WIDTH-1:0]                mux_out_q, mux_out_d;
    logic                            out_valid_q, out_valid_d;

    logic [SELW-1:0]                 ptr, sel_idx;
    logic [WIDTH-1:0]                data_sel;
    logic                            can_accept, accept;
    logic [CHANNELS-1:0]             sel_oh, grant_fix, rot_valid, rot_grant, grant_rr, grant;
    logic [CHANNELS-1:0]             din_ready;
    logic [2*CHANNELS-1:0]           dbl_valid, dbl_grant;
    logic [CHANNELS-1:0][WIDTH-1:0]  lane_data;

    assign can_accept = !out_valid_q || bus.out_ready;

    // Round-robin: rotate valids so the scan start sits at bit 0, isolate the
    // lowest set bit, then rotate the one-hot back to channel positions.
    always_comb begin
        sel_oh    = {{(CHANNELS-1){1'b0}}, 1'b1} << bus.mux_ctl;
        grant_fix = bus.din_valid & sel_oh;
        ptr       = (last_grant_q == SELW'(CHANNELS-1)) ? '0 : last_grant_q + 1'b1;
        dbl_valid = {bus.din_valid, bus.din_valid} >> ptr;
        rot_valid = dbl_valid[CHANNELS-1:0];
        rot_grant = rot_valid & (~rot_valid + 1'b1);
        dbl_grant = {rot_grant, rot_grant} << ptr;
        grant_rr  = dbl_grant[2*CHANNELS-1:CHANNELS];
        grant     = bus.mode ? grant_rr : grant_fix;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        mux_rr_nd_lane #(.WIDTH(WIDTH)) u_lane (
            .grant      (grant[i]),
            .can_accept (can_accept),
            .reset      (reset),
            .din        (bus.din[i*WIDTH +: WIDTH]),
            .ready      (din_ready[i]),
            .data       (lane_data[i])
        );
    end

    assign bus.din_ready = din_ready;
    assign accept        = |(bus.din_valid & din_ready);

    always_comb begin
        data_sel = '0;
        sel_idx  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            data_sel = data_sel | lane_data[i];
            if (grant[i]) sel_idx = sel_idx | SELW'(i);
        end
    end

    always_comb begin
        mux_out_d    = mux_out_q;
        out_sel_d    = out_sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            mux_out_d   = data_sel;
            out_sel_d   = sel_idx;
            out_valid_d = 1'b1;
            if (bus.mode) last_grant_d = sel_idx;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mux_out_q    <= '0;
            out_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= SELW'(CHANNELS-1);
        end else begin
            mux_out_q    <= mux_out_d;
            out_sel_q    <= out_sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.mux_out   = mux_out_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mux_rr_nd.sv
// Scoreboard bench for mux_rr_nd: a reference grant model predicts din_ready
// and queues expected words, which are compared when the output stage shows them.
module tb_mux_rr_nd;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mux_rr_nd_if #(.WIDTH(32), .CHANNELS(4)) b4 ();
    mux_rr_nd_if #(.WIDTH(5),  .CHANNELS(3)) b3 ();

    mux_rr_nd #(.WIDTH(32), .CHANNELS(4)) dut4 (.clk(clk), .reset(rst), .bus(b4));
    mux_rr_nd #(.WIDTH(5),  .CHANNELS(3)) dut3 (.clk(clk), .reset(rst), .bus(b3));

    typedef struct { logic [31:0] d; logic [1:0] s; } exp_t;
    exp_t       sbq[$];
    int         m_last = 3;
    logic [3:0] m_er;
    int         errs = 0, checks = 0;

    function automatic logic [3:0] model_grant(logic md, logic [1:0] ctl, logic [3:0] v, int last);
        logic [3:0] g;
        g = '0;
        if (!md) g[ctl] = v[ctl];
        else begin
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (last + k) % 4;
                if (v[c]) begin g[c] = 1'b1; break; end
            end
        end
        return g;
    endfunction

    // Predict this cycle's din_ready from current inputs and the model state.
    task automatic pre(output logic [3:0] er);
        #1;
        er = '0;
        if (!rst && (sbq.size() == 0 || b4.out_ready))
            er = model_grant(b4.mode, b4.mux_ctl, b4.din_valid, m_last);
        m_er = er;
    endtask

    // Advance the model across the clock edge; leaves time at posedge+1.
    task automatic post();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            sbq.delete();
            m_last = 3;
        end else begin
            if (sbq.size() > 0 && b4.out_ready) void'(sbq.pop_front());
            for (int c = 0; c < 4; c++) begin
                if (m_er[c]) begin
                    e.d = b4.din[c*32 +: 32];
                    e.s = 2'(c);
                    sbq.push_back(e);
                    if (b4.mode) m_last = c;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset_fixed();
        logic [3:0] er;
        rst = 1'b1;
        b4.din = {32'd7, 32'hDEADBEEF, 32'd555555, 32'd123456};
        b4.din_valid = 4'b1111; b4.out_ready = 1'b1; b4.mode = 1'b0; b4.mux_ctl = 2'd0;
        for (int i = 0; i < 2; i++) begin
            pre(er);
            checks++;
            if (b4.din_ready !== 4'b0000) begin
                errs++; $display("FAIL reset_ready: got %b want 0000", b4.din_ready);
            end
            post();
        end
        checks++;
        if (b4.out_valid !== 1'b0 || b4.mux_out !== 32'd0 || b4.out_sel !== 2'd0) begin
            errs++; $display("FAIL reset_state: got v=%b d=%h s=%0d want v=0 d=0 s=0",
                             b4.out_valid, b4.mux_out, b4.out_sel);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            b4.mux_ctl = 2'(i);
            pre(er);
            checks++;
            if (b4.din_ready !== er || er !== (4'b0001 << i)) begin
                errs++; $display("FAIL fixed_ready ctl=%0d: got %b want %b", i, b4.din_ready, 4'b0001 << i);
            end
            post();
            checks++;
            if (sbq.size() != 1 || b4.out_valid !== 1'b1 || b4.mux_out !== sbq[0].d ||
                b4.out_sel !== sbq[0].s || b4.mux_out !== (i == 0 ? 32'd123456 : 32'd555555)) begin
                errs++; $display("FAIL fixed_out ctl=%0d: got v=%b d=%0d s=%0d", i,
                                 b4.out_valid, b4.mux_out, b4.out_sel);
            end
        end
    endtask

    task automatic test_rr_fair();
        logic [3:0] er;
        b4.mode = 1'b1; b4.din_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            pre(er);
            checks++;
            if (b4.din_ready !== er) begin
                errs++; $display("FAIL rr_ready cyc%0d: got %b want %b", i, b4.din_ready, er);
            end
            post();
            checks++;
            if (sbq.size() != 1 || b4.out_valid !== 1'b1 || b4.out_sel !== 2'(i % 4) ||
                b4.mux_out !== sbq[0].d || b4.out_sel !== sbq[0].s) begin
                errs++; $display("FAIL rr_seq cyc%0d: got v=%b s=%0d want v=1 s=%0d", i,
                                 b4.out_valid, b4.out_sel, i % 4);
            end
        end
    endtask

    task automatic test_rr_skip_wrap();
        logic [3:0] er;
        logic [1:0] want[5] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
        for (int i = 0; i < 5; i++) begin
            b4.din_valid = (i < 4) ? 4'b1010 : 4'b1011;
            pre(er);
            checks++;
            if (b4.din_ready !== er) begin
                errs++; $display("FAIL skip_ready cyc%0d: got %b want %b", i, b4.din_ready, er);
            end
            post();
            checks++;
            if (sbq.size() != 1 || b4.out_valid !== 1'b1 || b4.out_sel !== want[i] ||
                b4.mux_out !== sbq[0].d) begin
                errs++; $display("FAIL skip_seq cyc%0d: got s=%0d want s=%0d", i, b4.out_sel, want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] er;
        b4.din_valid = 4'b1111; b4.mode = 1'b0; b4.mux_ctl = 2'd2;
        pre(er);
        post();
        checks++;
        if (b4.mux_out !== 32'hDEADBEEF || b4.out_sel !== 2'd2 || b4.out_valid !== 1'b1) begin
            errs++; $display("FAIL bp_load: got d=%h s=%0d want d=deadbeef s=2", b4.mux_out, b4.out_sel);
        end
        b4.mode = 1'b1; b4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pre(er);
            checks++;
            if (b4.din_ready !== 4'b0000 || er !== 4'b0000) begin
                errs++; $display("FAIL bp_ready cyc%0d: got %b want 0000", i, b4.din_ready);
            end
            post();
            checks++;
            if (b4.mux_out !== 32'hDEADBEEF || b4.out_sel !== 2'd2 || b4.out_valid !== 1'b1 ||
                b4.mux_out !== sbq[0].d) begin
                errs++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h s=%0d", i,
                                 b4.out_valid, b4.mux_out, b4.out_sel);
            end
        end
        b4.out_ready = 1'b1;
        pre(er);
        checks++;
        if (b4.din_ready !== 4'b0010 || er !== 4'b0010) begin
            errs++; $display("FAIL bp_release_ready: got %b want 0010", b4.din_ready);
        end
        post();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.mux_out !== 32'd555555 || b4.out_sel !== 2'd1 ||
            sbq.size() != 1 || b4.mux_out !== sbq[0].d) begin
            errs++; $display("FAIL bp_release_out: got v=%b d=%0d s=%0d want v=1 d=555555 s=1",
                             b4.out_valid, b4.mux_out, b4.out_sel);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] er;
        pre(er);
        post();
        b4.out_ready = 1'b0; rst = 1'b1;
        pre(er);
        checks++;
        if (b4.din_ready !== 4'b0000) begin
            errs++; $display("FAIL rst_mid_ready: got %b want 0000", b4.din_ready);
        end
        post();
        checks++;
        if (b4.out_valid !== 1'b0 || b4.mux_out !== 32'd0 || b4.out_sel !== 2'd0) begin
            errs++; $display("FAIL rst_mid_state: got v=%b d=%h s=%0d want v=0 d=0 s=0",
                             b4.out_valid, b4.mux_out, b4.out_sel);
        end
        rst = 1'b0; b4.out_ready = 1'b1;
        pre(er);
        checks++;
        if (b4.din_ready !== 4'b0001 || er !== 4'b0001) begin
            errs++; $display("FAIL rst_mid_first_grant: got %b want 0001", b4.din_ready);
        end
        post();
        checks++;
        if (b4.out_valid !== 1'b1 || b4.mux_out !== 32'd123456 || b4.out_sel !== 2'd0 ||
            b4.mux_out !== sbq[0].d) begin
            errs++; $display("FAIL rst_mid_out: got v=%b d=%0d s=%0d want v=1 d=123456 s=0",
                             b4.out_valid, b4.mux_out, b4.out_sel);
        end
        b4.din_valid = 4'b0000;
    endtask

    task automatic test_narrow();
        b3.mode = 1'b0; b3.mux_ctl = 2'd3; b3.din_valid = 3'b111;
        b3.din = {5'd20, 5'd9, 5'd4}; b3.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (b3.din_ready !== 3'b000) begin
                errs++; $display("FAIL narrow_oob_ready cyc%0d: got %b want 000", i, b3.din_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (b3.out_valid !== 1'b0) begin
                errs++; $display("FAIL narrow_oob_valid cyc%0d: got %b want 0", i, b3.out_valid);
            end
        end
        b3.mux_ctl = 2'd2;
        #1;
        checks++;
        if (b3.din_ready !== 3'b100) begin
            errs++; $display("FAIL narrow_ready: got %b want 100", b3.din_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b1 || b3.mux_out !== 5'd20 || b3.out_sel !== 2'd2) begin
            errs++; $display("FAIL narrow_out: got v=%b d=%0d s=%0d want v=1 d=20 s=2",
                             b3.out_valid, b3.mux_out, b3.out_sel);
        end
        b3.din_valid = 3'b000;
        @(posedge clk); #1;
        checks++;
        if (b3.out_valid !== 1'b0) begin
            errs++; $display("FAIL narrow_drain: got v=%b want 0", b3.out_valid);
        end
    endtask

    initial begin
        b3.mode = 1'b0; b3.mux_ctl = '0; b3.din = '0; b3.din_valid = '0; b3.out_ready = 1'b1;
        test_reset_fixed();
        test_rr_fair();
        test_rr_skip_wrap();
        test_backpressure();
        test_reset_mid();
        test_narrow();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/mux_rr_nd.md
Name: mux_rr_nd

Overview:
- Parametrised successor to the 2-input width-parametrised datapath mux.
- Selects one of CHANNELS valid/ready input channels of WIDTH bits and delivers it through a single-entry registered output stage.
- Two selection modes:
  - Fixed: explicit mux_ctl select.
  - Round-robin: fair arbitration.
- Used wherever several producers share one datapath sink, e.g. writeback result selection and memory-request merging.

Parameters:
WIDTH, 32, data width per channel (>=1)
CHANNELS, 4, number of input channels (>=2)
SELW, $clog2(CHANNELS), select/index width (derived; never overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
mode  input  1  0 = fixed select via mux_ctl, 1 = round-robin
mux_ctl  input  SELW  channel index used when mode=0
din  input  CHANNELS*WIDTH  flattened channel data; channel i = din[i*WIDTH +: WIDTH]
din_valid  input  CHANNELS  per-channel valid
din_ready  output  CHANNELS  per-channel ready (combinational)
mux_out  output  WIDTH  registered selected data
out_sel  output  SELW  registered index of channel that produced mux_out
out_valid  output  1  mux_out/out_sel hold a word
out_ready  input  1  sink accepts word

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk. Outputs after reset:
  - mux_out = 0, out_sel = 0, out_valid = 0.
  - Internal last_grant = CHANNELS-1, so channel 0 has first round-robin priority.
- Reset asserted mid-transfer drops any held word. No handshake completes on a cycle where reset is high.
- can_accept = !out_valid || out_ready, i.e. a full output stage can be refilled in the same cycle it drains.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[mux_ctl] = din_valid[mux_ctl].
    - If mux_ctl >= CHANNELS (non-power-of-2 CHANNELS), there is no grant.
    - Other channels are never granted in mode=0.
  - mode=1: scan channels starting at (last_grant+1) mod CHANNELS, wrapping. Grant the first with din_valid=1.
- din_ready[i] = grant[i] && can_accept && !reset. At most one din_ready is high per cycle.
- Transfer in: on a cycle with din_valid[i] && din_ready[i]:
  - Next edge: mux_out <= channel i data, out_sel <= i, out_valid <= 1.
  - In mode=1, last_grant <= i.
  - Latency: input to mux_out is 1 cycle.
- Transfer out: on a cycle with out_valid && out_ready:
  - The word is consumed.
  - If there is no simultaneous transfer in, out_valid <= 0 at the next edge.
- Simultaneous drain and fill: the new word replaces the old one with no bubble, giving 1 word/cycle sustained throughput.
- Hold (out_valid=1, out_ready=0): mux_out, out_sel and out_valid stay stable; all din_ready = 0.
- last_grant updates only on an accepted transfer in mode=1. It is unchanged in mode=0 and on stalls.
- Mode switching takes effect combinationally on the next grant evaluation. A word already held in the output stage is unaffected.
- A producer must hold din and din_valid stable until accepted. The block does not check this.
- Bit widths are exact: no sign extension or truncation of data.

Test Plan:
1. Fixed mode (mirrors 2-input mux test), WIDTH=32, CHANNELS=4:
   - Stimulus: reset 2 cycles; din ch0..3 = 123456, 555555, 0xDEADBEEF, 7; all valid; out_ready=1; mode=0; mux_ctl=0 then 1.
   - Required: mux_out = 123456 with out_sel=0 one cycle after reset release, then 555555 with out_sel=1 the cycle after mux_ctl changes; din_ready is only ever high on the selected channel.
2. Round-robin fairness:
   - Stimulus: mode=1; all 4 channels permanently valid; out_ready=1.
   - Required: out_sel sequence 0,1,2,3,0,1,… with out_valid continuously 1 and no bubbles.
3. Round-robin skip and wrap:
   - Stimulus: mode=1; only ch1 and ch3 valid.
   - Required: out_sel sequence 1,3,1,3. After the last grant on ch3, ch0 becomes valid and is granted before ch1.
4. Backpressure:
   - Stimulus: out_valid=1 holding 0xDEADBEEF; out_ready=0 for 3 cycles.
   - Required: mux_out and out_sel stable for all 3 cycles; all din_ready=0; last_grant unchanged; on out_ready=1 the next word loads the same cycle it is drained.
5. Reset mid-operation:
   - Stimulus: assert reset while out_valid=1 and out_ready=0.
   - Required: next edge gives out_valid=0, mux_out=0, out_sel=0; after release, the first round-robin grant goes to ch0.
6. Width and depth variant, WIDTH=5, CHANNELS=3:
   - Stimulus: mode=0, mux_ctl=3.
   - Required: no din_ready asserted and out_valid stays 0. Then mux_ctl=2 with din=20 gives mux_out=20 one cycle after acceptance.
